// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM memory-port arbiter.
// Contents:
//   arb_state_e     - arbiter FSM states
//   DM_* constants  - DMType encodings from the decoder
//   dm_misaligned() - natural-alignment test for a DM access
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // Words need addr[1:0]==0 and halves need addr[0]==0. Bytes are always aligned.
  function automatic logic dm_misaligned(input logic [2:0] dm_type, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (dm_type)
      DM_WORD:            bad = (addr_lo != 2'b00);
      DM_HALF, DM_HALF_U: bad = addr_lo[0];
      default:            bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the unified memory.
// Signal groups:
//   if_*   instruction-fetch request / grant / return data
//   dm_*   data-memory request / grant / return data / misalignment error
//   mem_*  single-ported memory access strobe, fields and read data
// Modports:
//   slave  - the arbiter (consumes requests and mem_rdata)
//   master - the environment (CPU stages plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_type;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_type, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, dm_err,
           mem_en, mem_we, mem_type, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_type, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, dm_err,
           mem_en, mem_we, mem_type, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_align_chk.sv
// Combinational DM misalignment detector, built only when MEM_ARB_ALIGN_CHECK_EN is defined.
// Ports:
//   dm_type    in  3  DMType of the request
//   addr_lo    in  2  dm_addr[1:0]
//   misaligned out 1  access violates natural alignment for its size
`ifdef MEM_ARB_ALIGN_CHECK_EN
module mem_align_chk
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] dm_type,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);
  assign misaligned = dm_misaligned(dm_type, addr_lo);
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the IF and DM requesters.
// Each access: grant in IDLE (cycle T), data/completion at T+MEM_LAT, next grant at T+MEM_LAT+1.
// DM has priority; IF is forced after IF_STARVE_MAX consecutive DM wins (0 = never forced).
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of mem_port_arbiter_if (IF, DM and memory signal groups)
// Build option: MEM_ARB_ALIGN_CHECK_EN - misaligned DM accesses are granted but never reach
//   memory; they complete with dm_valid+dm_err. Without it dm_err is tied 0.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 2,
  parameter int IF_STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam int SW = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(IF_STARVE_MAX);

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] cnt);
    return (cnt == STARVE_TOP) ? cnt : cnt + 1'b1;
  endfunction

  arb_state_e        state, state_nxt;
  logic [LW-1:0]     lat_cnt, lat_cnt_nxt;
  logic [SW-1:0]     starve_cnt, starve_cnt_nxt;
  logic              grant_if, grant_dm, issue, misaligned;
  logic              if_valid, dm_valid, dm_data_ok;
  logic              issue_we;
  logic [2:0]        issue_type;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  logic              we_q;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;

  mem_align_chk u_align_chk (
    .dm_type    (bus.dm_type),
    .addr_lo    (bus.dm_addr[1:0]),
    .misaligned (misaligned)
  );

  assign dm_data_ok = dm_valid & ~err_q;
  assign bus.dm_err = dm_valid & err_q;
`else
  assign misaligned = 1'b0;
  assign dm_data_ok = dm_valid;
  assign bus.dm_err = 1'b0;
`endif

  // Everything is gated off while rst is high so a reset cycle never starts or finishes an access.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    grant_if       = 1'b0;
    grant_dm       = 1'b0;
    if_valid       = 1'b0;
    dm_valid       = 1'b0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (bus.dm_req && bus.if_req) begin
            if (IF_STARVE_MAX != 0 && starve_cnt == STARVE_TOP) grant_if = 1'b1;
            else                                                grant_dm = 1'b1;
          end else if (bus.dm_req) begin
            grant_dm = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
          if (grant_if) begin
            state_nxt      = ARB_BUSY_IF;
            lat_cnt_nxt    = LAT_LOAD;
            starve_cnt_nxt = '0;
          end else if (grant_dm) begin
            state_nxt      = ARB_BUSY_DM;
            lat_cnt_nxt    = LAT_LOAD;
            starve_cnt_nxt = bus.if_req ? starve_inc(starve_cnt) : '0;
          end else begin
            starve_cnt_nxt = '0;
          end
        end
        ARB_BUSY_IF: begin
          if (lat_cnt == '0) begin
            if_valid  = 1'b1;
            state_nxt = ARB_IDLE;
          end else begin
            lat_cnt_nxt = lat_cnt - 1'b1;
          end
        end
        ARB_BUSY_DM: begin
          if (lat_cnt == '0) begin
            dm_valid  = 1'b1;
            state_nxt = ARB_IDLE;
          end else begin
            lat_cnt_nxt = lat_cnt - 1'b1;
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  // A misaligned DM grant occupies the port for the normal latency but never strobes memory.
  assign issue       = grant_if | (grant_dm & ~misaligned);
  assign issue_we    = grant_dm & bus.dm_we;
  assign issue_type  = grant_dm ? bus.dm_type : DM_WORD;
  assign issue_addr  = grant_dm ? bus.dm_addr : bus.if_addr;
  assign issue_wdata = grant_dm ? bus.dm_wdata : wdata_q;

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.if_valid  = if_valid;
  assign bus.dm_valid  = dm_valid;
  assign bus.if_rdata  = if_valid ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = dm_data_ok ? bus.mem_rdata : dm_rdata_q;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue ? issue_we    : we_q;
  assign bus.mem_type  = issue ? issue_type  : type_q;
  assign bus.mem_addr  = issue ? issue_addr  : addr_q;
  assign bus.mem_wdata = issue ? issue_wdata : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      type_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (issue) begin
        we_q    <= issue_we;
        type_q  <= issue_type;
        addr_q  <= issue_addr;
        wdata_q <= issue_wdata;
      end
      if (if_valid)   if_rdata_q <= bus.mem_rdata;
      if (dm_data_ok) dm_rdata_q <= bus.mem_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (grant_dm)   err_q <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and IF_STARVE_MAX=2.
// Per-cycle vector table for IF-only, DM+IF collision, store and mid-access reset,
// followed by hand sequences for the starvation rotation and the alignment option.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .IF_STARVE_MAX(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rst, ireq, iaddr, dreq, dwe, dtype, daddr, dwdata, mrd, chk;
    logic [31:0] ignt, ivld, irdata, dgnt, dvld, drdata, men, mwe, mtype, maddr, mwdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int   exp_dm [6] = '{1, 1, 0, 1, 1, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_type = 3'b000;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ireq iaddr dreq dwe dtype daddr dwdata mrd chk | ignt ivld irdata dgnt dvld drdata men mwe mtype maddr mwdata
    vecs[0]  = '{0,1,32'h100,0,0,0,0,0,0,1,             1,0,0,0,0,0,1,0,0,32'h100,0};
    vecs[1]  = '{0,0,0,0,0,0,0,0,0,1,                   0,0,0,0,0,0,0,0,0,32'h100,0};
    vecs[2]  = '{0,1,32'h104,0,0,0,0,0,32'h00500093,1,  0,1,32'h00500093,0,0,0,0,0,0,32'h100,0};
    vecs[3]  = '{0,1,32'h104,0,0,0,0,0,32'hDEADBEEF,1,  1,0,32'h00500093,0,0,0,1,0,0,32'h104,0};
    vecs[4]  = '{0,0,0,0,0,0,0,0,0,1,                   0,0,32'h00500093,0,0,0,0,0,0,32'h104,0};
    vecs[5]  = '{0,0,0,0,0,0,0,0,32'h11111111,1,        0,1,32'h11111111,0,0,0,0,0,0,32'h104,0};
    vecs[6]  = '{0,1,32'h108,1,0,0,32'h2000,0,0,1,      0,0,32'h11111111,1,0,0,1,0,0,32'h2000,0};
    vecs[7]  = '{0,1,32'h108,0,0,0,0,0,0,1,             0,0,32'h11111111,0,0,0,0,0,0,32'h2000,0};
    vecs[8]  = '{0,1,32'h108,0,0,0,0,0,32'hCAFEF00D,1,  0,0,32'h11111111,0,1,32'hCAFEF00D,0,0,0,32'h2000,0};
    vecs[9]  = '{0,1,32'h108,0,0,0,0,0,0,1,             1,0,32'h11111111,0,0,32'hCAFEF00D,1,0,0,32'h108,0};
    vecs[10] = '{0,0,0,0,0,0,0,0,0,1,                   0,0,32'h11111111,0,0,32'hCAFEF00D,0,0,0,32'h108,0};
    vecs[11] = '{0,0,0,0,0,0,0,0,32'h22222222,1,        0,1,32'h22222222,0,0,32'hCAFEF00D,0,0,0,32'h108,0};
    vecs[12] = '{0,0,0,1,1,3,32'h2003,32'hAB,0,1,       0,0,32'h22222222,1,0,32'hCAFEF00D,1,1,3,32'h2003,32'hAB};
    vecs[13] = '{0,0,0,0,0,0,0,0,0,1,                   0,0,32'h22222222,0,0,32'hCAFEF00D,0,1,3,32'h2003,32'hAB};
    vecs[14] = '{0,0,0,0,0,0,0,0,32'hCAFEF00D,1,        0,0,32'h22222222,0,1,32'hCAFEF00D,0,1,3,32'h2003,32'hAB};
    vecs[15] = '{0,0,0,1,0,0,32'h2008,0,0,1,            0,0,32'h22222222,1,0,32'hCAFEF00D,1,0,0,32'h2008,0};
    vecs[16] = '{1,0,0,0,0,0,0,0,0,0,                   0,0,0,0,0,0,0,0,0,0,0};
    vecs[17] = '{0,0,0,0,0,0,0,0,32'h77,1,              0,0,0,0,0,0,0,0,0,0,0};
    vecs[18] = '{0,1,32'h200,0,0,0,0,0,0,1,             1,0,0,0,0,0,1,0,0,32'h200,0};
    vecs[19] = '{0,0,0,0,0,0,0,0,0,1,                   0,0,0,0,0,0,0,0,0,32'h200,0};
    vecs[20] = '{0,0,0,0,0,0,0,0,32'h33333333,1,        0,1,32'h33333333,0,0,0,0,0,0,32'h200,0};

    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    check("reset if_gnt",   32'(bus.if_gnt),   0);
    check("reset dm_gnt",   32'(bus.dm_gnt),   0);
    check("reset mem_en",   32'(bus.mem_en),   0);
    check("reset mem_addr", bus.mem_addr,      0);
    check("reset if_rdata", bus.if_rdata,      0);
    check("reset dm_err",   32'(bus.dm_err),   0);

    for (int i = 0; i < NV; i++) begin
      tick();
      rst           = vecs[i].rst[0];
      bus.if_req    = vecs[i].ireq[0];
      bus.if_addr   = vecs[i].iaddr;
      bus.dm_req    = vecs[i].dreq[0];
      bus.dm_we     = vecs[i].dwe[0];
      bus.dm_type   = vecs[i].dtype[2:0];
      bus.dm_addr   = vecs[i].daddr;
      bus.dm_wdata  = vecs[i].dwdata;
      bus.mem_rdata = vecs[i].mrd;
      #4;
      if (vecs[i].chk[0]) begin
        check($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),   vecs[i].ignt);
        check($sformatf("v%0d if_valid", i),  32'(bus.if_valid), vecs[i].ivld);
        check($sformatf("v%0d if_rdata", i),  bus.if_rdata,      vecs[i].irdata);
        check($sformatf("v%0d dm_gnt", i),    32'(bus.dm_gnt),   vecs[i].dgnt);
        check($sformatf("v%0d dm_valid", i),  32'(bus.dm_valid), vecs[i].dvld);
        check($sformatf("v%0d dm_rdata", i),  bus.dm_rdata,      vecs[i].drdata);
        check($sformatf("v%0d dm_err", i),    32'(bus.dm_err),   0);
        check($sformatf("v%0d mem_en", i),    32'(bus.mem_en),   vecs[i].men);
        check($sformatf("v%0d mem_we", i),    32'(bus.mem_we),   vecs[i].mwe);
        check($sformatf("v%0d mem_type", i),  32'(bus.mem_type), vecs[i].mtype);
        check($sformatf("v%0d mem_addr", i),  bus.mem_addr,      vecs[i].maddr);
        check($sformatf("v%0d mem_wdata", i), bus.mem_wdata,     vecs[i].mwdata);
      end
    end

    // Both requesters held continuously: grant order DM,DM,IF,DM,DM,IF.
    for (int k = 0; k < 6; k++) begin
      tick();
      drive_idle();
      bus.if_req = 1'b1; bus.if_addr = 32'h10C;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h3000;
      #4;
      check($sformatf("rot%0d dm_gnt", k),   32'(bus.dm_gnt), exp_dm[k]);
      check($sformatf("rot%0d if_gnt", k),   32'(bus.if_gnt), 1 - exp_dm[k]);
      check($sformatf("rot%0d mem_addr", k), bus.mem_addr, (exp_dm[k] != 0) ? 32'h3000 : 32'h10C);
      tick();
      #4;
      check($sformatf("rot%0d busy gnt", k), 32'({bus.if_gnt, bus.dm_gnt}), 0);
      tick();
      bus.mem_rdata = 32'hA0 + k;
      #4;
      if (exp_dm[k] != 0) begin
        check($sformatf("rot%0d dm_valid", k), 32'(bus.dm_valid), 1);
        check($sformatf("rot%0d dm_rdata", k), bus.dm_rdata, 32'hA0 + k);
      end else begin
        check($sformatf("rot%0d if_valid", k), 32'(bus.if_valid), 1);
        check($sformatf("rot%0d if_rdata", k), bus.if_rdata, 32'hA0 + k);
      end
    end

    tick();
    drive_idle();
    bus.dm_req = 1'b1; bus.dm_type = 3'b000; bus.dm_addr = 32'h2002;
    #4;
    check("lw2002 dm_gnt", 32'(bus.dm_gnt), 1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("lw2002 mem_en", 32'(bus.mem_en), 0);
`else
    check("lw2002 mem_en",   32'(bus.mem_en), 1);
    check("lw2002 mem_addr", bus.mem_addr, 32'h2002);
`endif
    tick();
    drive_idle();
    tick();
    bus.mem_rdata = 32'h44;
    #4;
    check("lw2002 dm_valid", 32'(bus.dm_valid), 1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("lw2002 dm_err", 32'(bus.dm_err), 1);
`else
    check("lw2002 dm_err",   32'(bus.dm_err), 0);
    check("lw2002 dm_rdata", bus.dm_rdata, 32'h44);
`endif

    tick();
    drive_idle();
    bus.dm_req = 1'b1; bus.dm_type = 3'b000; bus.dm_addr = 32'h2004;
    #4;
    check("lw2004 dm_gnt", 32'(bus.dm_gnt), 1);
    check("lw2004 mem_en", 32'(bus.mem_en), 1);
    tick();
    drive_idle();
    tick();
    bus.mem_rdata = 32'h55;
    #4;
    check("lw2004 dm_valid", 32'(bus.dm_valid), 1);
    check("lw2004 dm_err",   32'(bus.dm_err), 0);
    check("lw2004 dm_rdata", bus.dm_rdata, 32'h55);

    tick();
    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
